popcnt_seq: RTL and testbench

POPCNT_SEQ -- requirements
Module: popcnt_seq

---
 rtl/popcnt_seq.sv | 110 +++++++++++
 tb/tb_popcnt_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/popcnt_seq.sv
// rtl/popcnt_seq.sv - sequential 20-bit population count using one shared 5-bit ones counter
//
// Counts the ones in a 20-bit word by splitting it into four 5-bit slices.
// A single 5-input ones counter handles one slice per clock.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset
//   start  in   1   begin a count; sampled only while idle
//   din    in  20   operand, captured on the accepting edge
//   busy   out  1   count in progress
//   done   out  1   one-cycle pulse, cnt valid
//   cnt    out  5   ones in the captured operand (0..20), held until next completion
//
// Compile option: POPCNT_EARLY_EXIT_EN - finish as soon as the remaining
// shifted operand is all-zero instead of always walking four slices.

module popcnt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] din,
    output logic        busy,
    output logic        done,
    output logic [4:0]  cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [19:0] r_sr;
    logic [4:0]  r_acc;
    logic [4:0]  r_cnt;
    logic [1:0]  r_idx;

    logic [2:0]  w_slice_ones;
    logic [4:0]  w_acc_sum;
    logic        w_early;
    logic        w_last;

    // Shared ones counter: always looks at the low slice of the shift register.
    always_comb begin
        w_slice_ones = {2'b00, r_sr[0]} + {2'b00, r_sr[1]} + {2'b00, r_sr[2]}
                     + {2'b00, r_sr[3]} + {2'b00, r_sr[4]};
    end

    // Maximum total is 20, so a 5-bit sum never wraps.
    assign w_acc_sum = r_acc + {2'b00, w_slice_ones};
    assign w_last    = (r_idx == 2'd3);

`ifdef POPCNT_EARLY_EXIT_EN
    // Nothing left to count once the remaining bits are all zero.
    assign w_early = (r_sr == 20'd0);
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_early || w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sr    <= 20'd0;
            r_acc   <= 5'd0;
            r_idx   <= 2'd0;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr  <= din;
                        r_acc <= 5'd0;
                        r_idx <= 2'd0;
                    end
                end
                S_RUN: begin
                    if (w_early) begin
                        r_cnt <= r_acc;
                    end else begin
                        r_acc <= w_acc_sum;
                        r_sr  <= r_sr >> 5;
                        r_idx <= r_idx + 2'd1;
                        // Final slice: publish the completed sum on the DONE-entry edge.
                        if (w_last) r_cnt <= w_acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign cnt  = r_cnt;

endmodule

// File: tb/tb_popcnt_seq.sv
// tb/tb_popcnt_seq.sv - self-checking bench for popcnt_seq

module tb_popcnt_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] din;
    logic        busy;
    logic        done;
    logic [4:0]  cnt;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];

    typedef struct {
        logic [19:0] din;
        logic [4:0]  exp_cnt;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    popcnt_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] model_cnt(input logic [19:0] d);
        int n = 0;
        for (int i = 0; i < 20; i++) if (d[i]) n++;
        return 5'(n);
    endfunction

    // Cycle index (1 = cycle after the accepting edge) in which done is high.
    function automatic int model_lat(input logic [19:0] d);
`ifdef POPCNT_EARLY_EXIT_EN
        int h = -1;
        for (int i = 0; i < 4; i++) if (d[5*i +: 5] != 5'd0) h = i;
        if (h < 0)  return 2;
        if (h == 3) return 5;
        return h + 3;
`else
        return 5;
`endif
    endfunction

    // Scoreboard: every done pops one expected count.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("busy_done_exclusive", int'(busy), 0);
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                chk("cnt", int'(cnt), int'(exp_q.pop_front()));
            end
        end
    end

    // Call at a negedge with the DUT idle.
    task automatic run_op(input logic [19:0] d, input int lat, input logic [4:0] ec);
        bit seen = 0;
        start = 1'b1;
        din   = d;
        @(posedge clk);
        exp_q.push_back(ec);
        #1;
        start = 1'b0;
        din   = 20'($urandom);
        for (int c = 1; c <= lat + 3 && !seen; c++) begin
            @(negedge clk);
            if (c == 2 && lat >= 3) start = 1'b1;
            if (c == 3) start = 1'b0;
            if (done) begin
                seen = 1;
                chk("latency", c, lat);
            end else if (c < lat) begin
                chk("busy_in_run", int'(busy), 1);
            end
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_width", int'(done), 0);
        chk("busy_after", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] tbl_din[8];
        int          lat;
        int          per;
        logic [4:0]  hold;

        tbl_din[0] = 20'hFFFFF;
        tbl_din[1] = 20'hA5A5A;
        tbl_din[2] = 20'h00000;
        tbl_din[3] = 20'h0001F;
        tbl_din[4] = 20'h80001;
        tbl_din[5] = 20'h12345;
        tbl_din[6] = 20'($urandom);
        tbl_din[7] = 20'($urandom);
        for (int i = 0; i < 8; i++) begin
            vecs[i].din     = tbl_din[i];
            vecs[i].exp_cnt = model_cnt(tbl_din[i]);
            vecs[i].exp_lat = model_lat(tbl_din[i]);
        end

        rst   = 1'b1;
        start = 1'b0;
        din   = 20'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_cnt", int'(cnt), 0);
        rst = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].din, vecs[i].exp_lat, vecs[i].exp_cnt);
            hold = vecs[i].exp_cnt;
            repeat (2) @(negedge clk);
            chk("cnt_hold_idle", int'(cnt), int'(hold));
        end

        // Back-to-back with start held high.
        lat   = model_lat(20'h0000F);
        per   = lat + 1;
        start = 1'b1;
        din   = 20'h0000F;
        for (int e = 0; e < 3 * per; e++) begin
            @(posedge clk);
            if (e % per == 0) exp_q.push_back(5'd4);
            @(negedge clk);
            chk("b2b_done", int'(done), int'(e % per == lat - 1));
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during RUN aborts the count.
        start = 1'b1;
        din   = 20'h80001;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cnt", int'(cnt), 0);
        repeat (8) @(negedge clk);
        chk("abort_quiet_cnt", int'(cnt), 0);

        run_op(20'h80001, model_lat(20'h80001), 5'd2);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
